serv_wb_mem_responder: RTL and testbench
========================================

Name: serv_wb_mem_responder

Overview:
- Wishbone-style responder that serves the SERV instruction and data buses from a single-port RAM32 macro (word-addressed, byte-write-enabled, synchronous read).
- Also serves a byte-wide host load port used to preload program memory from the pads.
- Replaces the "ack = cyc" tie-off with a real arbitrated access FSM and correct read-latency alignment.
- Sits between serv_top and RAM32 in the TT top level.

Parameters:
- AW, 5, RAM word-address width; RAM holds 2^AW 32-bit words, byte span 2^(AW+2).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- i_ibus_cyc  input  1  instruction fetch request, held until ack
- i_ibus_adr  input  32  fetch byte address
- o_ibus_rdt  output  32  fetch data, valid with ack
- o_ibus_ack  output  1  fetch acknowledge, one-cycle pulse
- i_dbus_cyc  input  1  data request, held until ack
- i_dbus_adr  input  32  data byte address
- i_dbus_we  input  1  1 = write
- i_dbus_dat  input  32  write data
- i_dbus_sel  input  4  byte-lane enables, bit n = bits [8n+7:8n]
- o_dbus_rdt  output  32  read data, valid with ack
- o_dbus_ack  output  1  data acknowledge, one-cycle pulse
- i_host_we  input  1  host byte-write request, held until ack
- i_host_adr  input  AW+2  host byte address
- i_host_dat  input  8  host byte
- o_host_ack  output  1  host write done, one-cycle pulse
- o_ram_en  output  1  RAM EN0
- o_ram_a  output  AW  RAM A0
- o_ram_we  output  4  RAM WE0 byte enables
- o_ram_di  output  32  RAM Di0
- i_ram_do  input  32  RAM Do0, valid the cycle after an enabled read edge
- o_bus_err  output  1  sticky unmapped-address flag

Behaviour:
- Reset (rst_n low, async): FSM = IDLE; all outputs 0; latched grant, address, data and lanes cleared; in-flight transaction discarded, no ack issued.
- After reset, a request still held high is re-arbitrated from IDLE.
- States: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE: sample requests. Priority: host > dbus > ibus.
  - On a grant, latch master id, word address, write data, byte lanes and a mapped flag.
  - Go to ACCESS next cycle.
  - No request: stay in IDLE, RAM outputs 0.
- ACCESS (one cycle): o_ram_en=1; o_ram_a = latched word address.
  - dbus write: o_ram_we = sel, o_ram_di = dat.
  - host write: lane = adr[1:0]; o_ram_we = one-hot lane; o_ram_di = {24'b0,dat} << 8*lane.
  - Reads (ibus, or dbus with we=0): o_ram_we=0.
- RESP (one cycle): ack of the granted master = 1; rdt of that master = i_ram_do (reads only); -> IDLE.
- Latency: request sampled high in cycle N -> ack in cycle N+2, for reads and writes alike. Back-to-back: next grant earliest in cycle N+3. Throughput is one access per 3 cycles.
- Non-granted master's ack and rdt are 0. rdt is 0 whenever its ack is 0 (gated, not held).
- Word address = adr[AW+1:2]. Mapped iff adr[31:AW+2]==0; the host port is always mapped.
- Unmapped access:
  - o_ram_en=0 in ACCESS and no RAM write.
  - Ack is still issued in RESP with rdt=0.
  - o_bus_err set and held until reset.
- A request dropped before ack (cyc low during ACCESS/RESP) is not aborted: the RAM write still occurs and the ack pulse is still issued.
- A master holding cyc after its ack is treated as a new request in the next IDLE cycle.
- A waiting lower-priority master is never starved by a single request. A continuously re-issued host request can starve CPU buses; this is acceptable, since host loading happens with the CPU in reset.
- dbus write with sel=0000: RAM EN asserted, no bytes written, ack issued.

Test Plan:
- Preload word 3 = 0xDEADBEEF via host writes to bytes 12..15 -> four o_host_ack pulses, each 2 cycles after the request. Then an ibus read of adr 0x0C -> o_ibus_ack 2 cycles after cyc, o_ibus_rdt=0xDEADBEEF.
- dbus write adr 0x08, dat 0x11223344, sel=0100 over a word of 0 -> read back 0x00220000.
- ibus and dbus cyc raised in the same cycle -> dbus acked in cycle N+2, ibus in N+5. No overlapping acks.
- dbus read adr 0x00001000 (AW=5) -> ack with rdt=0, o_ram_en never asserted, o_bus_err=1 and stays 1.
- rst_n pulsed low while in ACCESS for a dbus write -> all outputs 0 immediately, no ack. With cyc still high after release, the write restarts and acks 2 cycles after the first IDLE cycle.
- Host and ibus requests simultaneous at adr 0x04 -> host write completes first. The ibus read then returns the newly written byte.

Source files
------------

// File: rtl/serv_wb_mem_responder.sv
// Arbitrated responder between the SERV instruction/data buses, the host byte-load
// port and a single-port RAM32 macro with synchronous read.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | sample requests, grant host > dbus > ibus, latch the access
// S_ACCESS | drive RAM port for one cycle (suppressed if unmapped)
// S_RESP   | RAM data valid; pulse ack of the granted master
module serv_wb_mem_responder #(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_ibus_cyc,
    input  logic [31:0]   i_ibus_adr,
    output logic [31:0]   o_ibus_rdt,
    output logic          o_ibus_ack,
    input  logic          i_dbus_cyc,
    input  logic [31:0]   i_dbus_adr,
    input  logic          i_dbus_we,
    input  logic [31:0]   i_dbus_dat,
    input  logic [3:0]    i_dbus_sel,
    output logic [31:0]   o_dbus_rdt,
    output logic          o_dbus_ack,
    input  logic          i_host_we,
    input  logic [AW+1:0] i_host_adr,
    input  logic [7:0]    i_host_dat,
    output logic          o_host_ack,
    output logic          o_ram_en,
    output logic [AW-1:0] o_ram_a,
    output logic [3:0]    o_ram_we,
    output logic [31:0]   o_ram_di,
    input  logic [31:0]   i_ram_do,
    output logic          o_bus_err
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
    typedef enum logic [1:0] {M_NONE, M_HOST, M_DBUS, M_IBUS} master_t;

    state_t          state, state_nxt;
    master_t         master, grant;
    logic [AW-1:0]   word_adr, g_adr;
    logic [31:0]     wdat, g_dat;
    logic [3:0]      lanes, g_lanes;
    logic            mapped, g_mapped;
    logic            is_read, g_read;
    logic [1:0]      host_lane;
    logic            unused_adr_bits;

    assign unused_adr_bits = ^{i_ibus_adr[1:0], i_dbus_adr[1:0]};
    assign host_lane       = i_host_adr[1:0];

    always_comb begin
        grant    = M_NONE;
        g_adr    = '0;
        g_dat    = '0;
        g_lanes  = '0;
        g_mapped = 1'b0;
        g_read   = 1'b0;
        if (i_host_we) begin
            grant    = M_HOST;
            g_adr    = i_host_adr[AW+1:2];
            g_dat    = {24'b0, i_host_dat} << {host_lane, 3'b000};
            g_lanes  = 4'b0001 << host_lane;
            g_mapped = 1'b1;
        end else if (i_dbus_cyc) begin
            grant    = M_DBUS;
            g_adr    = i_dbus_adr[AW+1:2];
            g_dat    = i_dbus_we ? i_dbus_dat : 32'h0;
            g_lanes  = i_dbus_we ? i_dbus_sel : 4'b0000;
            g_mapped = (i_dbus_adr[31:AW+2] == '0);
            g_read   = ~i_dbus_we;
        end else if (i_ibus_cyc) begin
            grant    = M_IBUS;
            g_adr    = i_ibus_adr[AW+1:2];
            g_mapped = (i_ibus_adr[31:AW+2] == '0);
            g_read   = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (grant != M_NONE) state_nxt = S_ACCESS;
            S_ACCESS: state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            master    <= M_NONE;
            word_adr  <= '0;
            wdat      <= '0;
            lanes     <= '0;
            mapped    <= 1'b0;
            is_read   <= 1'b0;
            o_bus_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && grant != M_NONE) begin
                master   <= grant;
                word_adr <= g_adr;
                wdat     <= g_dat;
                lanes    <= g_lanes;
                mapped   <= g_mapped;
                is_read  <= g_read;
            end
            if (state == S_ACCESS && !mapped) o_bus_err <= 1'b1;
        end
    end

    // Unmapped accesses keep the RAM idle but still complete on the bus.
    always_comb begin
        o_ram_en = (state == S_ACCESS) && mapped;
        o_ram_a  = o_ram_en ? word_adr : '0;
        o_ram_we = o_ram_en ? lanes : 4'b0000;
        o_ram_di = o_ram_en ? wdat : 32'h0;
    end

    always_comb begin
        o_host_ack = (state == S_RESP) && (master == M_HOST);
        o_dbus_ack = (state == S_RESP) && (master == M_DBUS);
        o_ibus_ack = (state == S_RESP) && (master == M_IBUS);
        o_dbus_rdt = (o_dbus_ack && is_read && mapped) ? i_ram_do : 32'h0;
        o_ibus_rdt = (o_ibus_ack && is_read && mapped) ? i_ram_do : 32'h0;
    end

endmodule

// File: tb/tb_serv_wb_mem_responder.sv
// Directed bench for serv_wb_mem_responder with a behavioural RAM32 model.
module tb_serv_wb_mem_responder;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_ibus_cyc = 1'b0;
    logic [31:0]   i_ibus_adr = '0;
    logic [31:0]   o_ibus_rdt;
    logic          o_ibus_ack;
    logic          i_dbus_cyc = 1'b0;
    logic [31:0]   i_dbus_adr = '0;
    logic          i_dbus_we = 1'b0;
    logic [31:0]   i_dbus_dat = '0;
    logic [3:0]    i_dbus_sel = '0;
    logic [31:0]   o_dbus_rdt;
    logic          o_dbus_ack;
    logic          i_host_we = 1'b0;
    logic [AW+1:0] i_host_adr = '0;
    logic [7:0]    i_host_dat = '0;
    logic          o_host_ack;
    logic          o_ram_en;
    logic [AW-1:0] o_ram_a;
    logic [3:0]    o_ram_we;
    logic [31:0]   o_ram_di;
    logic [31:0]   ram_do = '0;
    logic          o_bus_err;

    logic [31:0] mem [0:(1<<AW)-1] = '{default: 32'h0};

    int n_tests = 0;
    int n_fail  = 0;

    int          host_lat, dbus_lat, ibus_lat;
    logic [31:0] dbus_got, ibus_got;
    int          overlap, gate_err;
    logic        en_seen;

    serv_wb_mem_responder #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_ibus_cyc(i_ibus_cyc), .i_ibus_adr(i_ibus_adr),
        .o_ibus_rdt(o_ibus_rdt), .o_ibus_ack(o_ibus_ack),
        .i_dbus_cyc(i_dbus_cyc), .i_dbus_adr(i_dbus_adr), .i_dbus_we(i_dbus_we),
        .i_dbus_dat(i_dbus_dat), .i_dbus_sel(i_dbus_sel),
        .o_dbus_rdt(o_dbus_rdt), .o_dbus_ack(o_dbus_ack),
        .i_host_we(i_host_we), .i_host_adr(i_host_adr), .i_host_dat(i_host_dat),
        .o_host_ack(o_host_ack),
        .o_ram_en(o_ram_en), .o_ram_a(o_ram_a), .o_ram_we(o_ram_we),
        .o_ram_di(o_ram_di), .i_ram_do(ram_do), .o_bus_err(o_bus_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_ram_en) begin
            for (int b = 0; b < 4; b++)
                if (o_ram_we[b]) mem[o_ram_a][8*b +: 8] <= o_ram_di[8*b +: 8];
            ram_do <= mem[o_ram_a];
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Raise the selected requests together, then record each ack's cycle offset.
    task automatic run(input logic h_en, input logic [AW+1:0] h_adr, input logic [7:0] h_dat,
                       input logic d_en, input logic [31:0] d_adr, input logic d_we,
                       input logic [31:0] d_dat, input logic [3:0] d_sel,
                       input logic i_en, input logic [31:0] i_adr);
        int acks;
        host_lat = -1; dbus_lat = -1; ibus_lat = -1;
        dbus_got = 'x; ibus_got = 'x;
        overlap = 0; gate_err = 0; en_seen = 1'b0;
        @(posedge clk); #1;
        i_host_we = h_en; i_host_adr = h_adr; i_host_dat = h_dat;
        i_dbus_cyc = d_en; i_dbus_adr = d_adr; i_dbus_we = d_we;
        i_dbus_dat = d_dat; i_dbus_sel = d_sel;
        i_ibus_cyc = i_en; i_ibus_adr = i_adr;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            acks = int'(o_host_ack) + int'(o_dbus_ack) + int'(o_ibus_ack);
            if (acks > 1) overlap++;
            if (o_ram_en) en_seen = 1'b1;
            if ((!o_dbus_ack && o_dbus_rdt != 0) || (!o_ibus_ack && o_ibus_rdt != 0)) gate_err++;
            if (o_host_ack) begin host_lat = c; i_host_we = 1'b0; end
            if (o_dbus_ack) begin dbus_lat = c; dbus_got = o_dbus_rdt; i_dbus_cyc = 1'b0; end
            if (o_ibus_ack) begin ibus_lat = c; ibus_got = o_ibus_rdt; i_ibus_cyc = 1'b0; end
            if (!i_host_we && !i_dbus_cyc && !i_ibus_cyc) break;
        end
        i_host_we = 1'b0; i_dbus_cyc = 1'b0; i_ibus_cyc = 1'b0;
    endtask

    task automatic host_wr(input logic [AW+1:0] adr, input logic [7:0] dat, input string tag);
        run(1, adr, dat, 0, 0, 0, 0, 0, 0, 0);
        check(tag, host_lat, 2);
    endtask

    task automatic dbus_rd(input logic [31:0] adr, input logic [31:0] exp, input string tag);
        run(0, 0, 0, 1, adr, 0, 0, 0, 0, 0);
        check({tag, "_lat"}, dbus_lat, 2);
        check({tag, "_rdt"}, dbus_got, exp);
    endtask

    initial begin
        int c;
        #2;
        check("rst_ram_en", o_ram_en, 0);
        check("rst_acks", {o_host_ack, o_dbus_ack, o_ibus_ack}, 0);
        check("rst_rdt", o_ibus_rdt | o_dbus_rdt, 0);
        check("rst_bus_err", o_bus_err, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        host_wr(7'd12, 8'hEF, "host_b12_lat");
        host_wr(7'd13, 8'hBE, "host_b13_lat");
        host_wr(7'd14, 8'hAD, "host_b14_lat");
        host_wr(7'd15, 8'hDE, "host_b15_lat");
        run(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0C);
        check("ibus_w3_lat", ibus_lat, 2);
        check("ibus_w3_rdt", ibus_got, 32'hDEADBEEF);

        run(0, 0, 0, 1, 32'h08, 1, 32'h11223344, 4'b0100, 0, 0);
        check("dbus_wr_lat", dbus_lat, 2);
        check("dbus_wr_rdt0", dbus_got, 0);
        dbus_rd(32'h08, 32'h00220000, "dbus_rd_w2");

        run(0, 0, 0, 1, 32'h08, 0, 0, 0, 1, 32'h0C);
        check("both_dbus_lat", dbus_lat, 2);
        check("both_dbus_rdt", dbus_got, 32'h00220000);
        check("both_ibus_lat", ibus_lat, 5);
        check("both_ibus_rdt", ibus_got, 32'hDEADBEEF);
        check("both_overlap", overlap, 0);
        check("both_gating", gate_err, 0);

        run(0, 0, 0, 1, 32'h0C, 1, 32'hFFFFFFFF, 4'b0000, 0, 0);
        check("sel0_lat", dbus_lat, 2);
        check("sel0_en", en_seen, 1);
        dbus_rd(32'h0C, 32'hDEADBEEF, "sel0_rd");

        run(0, 0, 0, 1, 32'h00001000, 0, 0, 0, 0, 0);
        check("unmap_lat", dbus_lat, 2);
        check("unmap_rdt", dbus_got, 0);
        check("unmap_en", en_seen, 0);
        check("unmap_err", o_bus_err, 1);
        run(0, 0, 0, 1, 32'h00000100, 1, 32'h55555555, 4'b1111, 0, 0);
        check("unmap_wr_en", en_seen, 0);
        dbus_rd(32'h00, 32'h0, "unmap_wr_noalias");
        check("unmap_err_sticky", o_bus_err, 1);

        // Reset hits while the write is in ACCESS.
        @(posedge clk); #1;
        i_dbus_cyc = 1; i_dbus_adr = 32'h10; i_dbus_we = 1;
        i_dbus_dat = 32'hCAFEF00D; i_dbus_sel = 4'b1111;
        @(posedge clk); #1;
        check("rst_mid_access_en", o_ram_en, 1);
        rst_n = 1'b0; #1;
        check("rst_mid_ram_en", o_ram_en, 0);
        check("rst_mid_ram_we", o_ram_we, 0);
        check("rst_mid_ack", o_dbus_ack, 0);
        check("rst_mid_err_clr", o_bus_err, 0);
        @(posedge clk); @(negedge clk);
        check("rst_mid_no_ack", o_dbus_ack, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        c = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (o_dbus_ack) begin c = k; break; end
        end
        i_dbus_cyc = 0;
        check("rst_restart_lat", c, 2);
        dbus_rd(32'h10, 32'hCAFEF00D, "rst_restart_rd");

        run(1, 7'd4, 8'hA5, 0, 0, 0, 0, 0, 1, 32'h04);
        check("host_ibus_host_lat", host_lat, 2);
        check("host_ibus_ibus_lat", ibus_lat, 5);
        check("host_ibus_rdt", ibus_got, 32'h000000A5);
        check("host_ibus_overlap", overlap, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
